// File: rtl/pio_led_pwm_pkg.sv
// pio_led_pwm_pkg: register map and limits for the LED PWM output port
package pio_led_pwm_pkg;
  localparam logic [4:0] ADDR_DATA      = 5'd0;
  localparam logic [4:0] ADDR_MODE      = 5'd1;
  localparam logic [4:0] ADDR_OUTSET    = 5'd2;
  localparam logic [4:0] ADDR_OUTCLEAR  = 5'd3;
  localparam logic [4:0] ADDR_PRESCALE  = 5'd4;
  localparam logic [4:0] ADDR_OUTPUT    = 5'd6;
  localparam logic [4:0] ADDR_PHASE     = 5'd7;
  localparam logic [4:0] ADDR_DUTY_BASE = 5'd8;
  localparam int         MAX_WIDTH      = 24;
endpackage

// File: rtl/pio_pwm_timebase.sv
// pio_pwm_timebase: prescaled PWM phase counter with synchronous restart
module pio_pwm_timebase #(
  parameter int PRESC_BITS = 16,
  parameter int PWM_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESC_BITS-1:0] prescale,
  input  logic                  restart,
  output logic                  tick,
  output logic [PWM_BITS-1:0]   phase
);
  logic [PRESC_BITS-1:0] cnt;
  assign tick = ~restart & (cnt == prescale);
  // prescaler wraps at PRESCALE, phase advances on each tick; restart zeroes both
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt   <= '0;
      phase <= '0;
    end else begin
      cnt   <= (restart | tick) ? '0 : cnt + 1'b1;
      phase <= restart ? '0 : tick ? phase + 1'b1 : phase;
    end
endmodule

// File: rtl/pio_led_pwm.sv
// pio_led_pwm: Avalon-MM LED output port with per-channel PWM dimming
module pio_led_pwm
  import pio_led_pwm_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1,
  parameter int               PWM_BITS    = 8,
  parameter int               PRESC_BITS  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic                           wr, restart, tick;
  logic [WIDTH-1:0]               data, mode, pwm_on;
  logic [PRESC_BITS-1:0]          prescale;
  logic [PWM_BITS-1:0]            phase, duty_rd;
  logic [WIDTH-1:0][PWM_BITS-1:0] duty;

  assign wr      = chipselect & ~write_n;
  assign restart = wr & (address == ADDR_PRESCALE);

  pio_pwm_timebase #(.PRESC_BITS(PRESC_BITS), .PWM_BITS(PWM_BITS)) u_timebase (
    .clk      (clk),
    .reset_n  (reset_n),
    .prescale (prescale),
    .restart  (restart),
    .tick     (tick),
    .phase    (phase)
  );

  // register writes; OUTSET/OUTCLEAR modify DATA in place, unmapped slots fall through
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data     <= RESET_VALUE;
      mode     <= '0;
      prescale <= '0;
      duty     <= '0;
    end else if (wr) begin
      data     <= address == ADDR_DATA     ? writedata[WIDTH-1:0] :
                  address == ADDR_OUTSET   ? data | writedata[WIDTH-1:0] :
                  address == ADDR_OUTCLEAR ? data & ~writedata[WIDTH-1:0] : data;
      mode     <= address == ADDR_MODE ? writedata[WIDTH-1:0] : mode;
      prescale <= restart ? writedata[PRESC_BITS-1:0] : prescale;
      for (int i = 0; i < WIDTH; i++)
        if (address == 5'(ADDR_DUTY_BASE + i)) duty[i] <= writedata[PWM_BITS-1:0];
    end

  // static channels pass through, PWM channels are gated by phase < duty
  always_comb begin
    pwm_on = '1;
    for (int i = 0; i < WIDTH; i++) pwm_on[i] = ~mode[i] | (phase < duty[i]);
  end

  // LED pins are registered so they never glitch on the compare
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) out_port <= RESET_VALUE;
    else          out_port <= data & pwm_on;

  // duty readback; stays zero for slots beyond WIDTH
  always_comb begin
    duty_rd = '0;
    for (int i = 0; i < WIDTH; i++)
      if (address == 5'(ADDR_DUTY_BASE + i)) duty_rd = duty[i];
  end

  // zero-latency read mux, independent of chipselect
  always_comb
    readdata = address == ADDR_DATA     ? 32'(data)     :
               address == ADDR_MODE     ? 32'(mode)     :
               address == ADDR_PRESCALE ? 32'(prescale) :
               address == ADDR_OUTPUT   ? 32'(out_port) :
               address == ADDR_PHASE    ? 32'(phase)    : 32'(duty_rd);
endmodule

// File: doc/pio_led_pwm.md
Name: pio_led_pwm

Overview:
- Parametrised Avalon-MM output PIO for board LEDs; next generation of the system LED port.
- Adds per-channel mode (static or PWM dimming), atomic set/clear registers, a programmable PWM timebase and output readback.
- Sits on the Nios II data master as a zero-wait-state slave; `out_port` drives the LED pins directly.

Parameters:
- WIDTH, 10, number of output channels (1..24).
- RESET_VALUE, all ones (WIDTH bits), DATA and `out_port` value after reset.
- PWM_BITS, 8, PWM phase/duty resolution (1..16).
- PRESC_BITS, 16, prescaler width (1..32).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  5  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, read latency 0
- out_port  out  WIDTH  LED drive, registered

Interface (already decided):
- Reset reset_n: asynchronous, active-low.
- Clock: clk.

Behaviour:
- Write strobe `wr` = chipselect & ~write_n, sampled at posedge clk.
- Register map (word address):
  - 0 DATA: R/W [WIDTH-1:0].
  - 1 MODE: R/W; bit i = 1 puts channel i in PWM mode.
  - 2 OUTSET: W, DATA |= writedata; reads 0.
  - 3 OUTCLEAR: W, DATA &= ~writedata; reads 0.
  - 4 PRESCALE: R/W [PRESC_BITS-1:0].
  - 6 OUTPUT: RO, current `out_port`.
  - 7 PHASE: RO, current phase counter.
  - 8+i DUTY[i]: R/W [PWM_BITS-1:0], for i < WIDTH.
  - All other addresses and DUTY slots for i >= WIDTH: writes ignored, reads 0.
- Register bits above each field width: ignored on write, read as 0.
- Reads are combinational from `address`; chipselect is not required for readdata. Reads have no side effects.
- Timebase:
  - Prescaler counter counts 0..PRESCALE; on reaching PRESCALE it asserts `tick` and returns to 0.
  - PRESCALE = 0 gives a tick every clk.
  - Phase counter (PWM_BITS) increments on `tick` and wraps from all ones to 0. PWM period = (PRESCALE+1) * 2^PWM_BITS clk.
- A write to PRESCALE clears the prescaler and phase counters on the same edge. The new value takes effect from the next cycle.
- Channel output, computed per channel i and registered into `out_port` every clk:
  - MODE[i] = 0: `out_port[i]` = DATA[i].
  - MODE[i] = 1: `out_port[i]` = DATA[i] & (phase < DUTY[i]).
  - DUTY = 0 keeps the channel off. DUTY = all ones gives (2^PWM_BITS-1)/2^PWM_BITS on-time. DATA[i] = 0 forces off in either mode.
- Latency:
  - Write at edge N updates the register at edge N.
  - `out_port` reflects the change after edge N+1.
  - OUTPUT readback follows `out_port`.
- Changing DUTY or MODE mid-period takes effect on the next compare; there is no period-boundary shadowing.
- Reset values:
  - DATA = RESET_VALUE, `out_port` = RESET_VALUE.
  - MODE = 0, PRESCALE = 0, all DUTY = 0, counters = 0.
  - readdata reflects the reset register values.
- Reset asserted mid-period: counters and registers return to reset values immediately (asynchronous). They restart from 0 on the first edge after deassertion.

Decomposition:
- Package `pio_led_pwm_pkg`:
  - address constants ADDR_DATA, ADDR_MODE, ADDR_OUTSET, ADDR_OUTCLEAR, ADDR_PRESCALE, ADDR_OUTPUT, ADDR_PHASE, ADDR_DUTY_BASE.
  - max-WIDTH limit constant.
- Sub-module `pio_pwm_timebase` (params PRESC_BITS, PWM_BITS):
  - inputs clk, reset_n, prescale, restart.
  - outputs tick, phase.

Test Plan:
- Reset check: reset, then read addr 0 -> 0x3FF; `out_port` = 0x3FF; read 1 -> 0; read 4 -> 0.
- Set/clear:
  - Write DATA = 0x0F0, then OUTSET = 0x003 -> DATA 0x0F3.
  - Then OUTCLEAR = 0x030 -> 0x0C3.
  - `out_port` follows one clk after each write; reads of addr 2 and 3 return 0.
- PWM duty:
  - MODE = 0x001, DATA = 0x001, PRESCALE = 0, DUTY[0] = 64.
  - Expect `out_port[0]` high for 64 of every 256 clk, measured over 4 periods.
  - DUTY[0] = 0 -> constantly low; DUTY[0] = 255 -> low exactly 1 clk per 256.
- Prescaler restart:
  - PRESCALE = 3; PHASE readback increments every 4 clk.
  - Rewriting PRESCALE = 3 mid-period -> PHASE reads 0 on the next cycle.
- Unmapped/out-of-range: with WIDTH = 10, write 0xFF to addr 18 and addr 5 -> read 0; no register or output change.
- Async reset mid-PWM: assert reset_n low between edges -> `out_port` = 0x3FF and PHASE = 0 without waiting for clk.
